// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared definitions for the cpu run controller.
//   state_t     - run-controller FSM encoding (3 bits)
//   TOHOST_PASS - exit code that counts as a passing run
package cpu_run_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_RUN     = 3'd2,
        S_DONE    = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam logic [31:0] TOHOST_PASS = 32'd1;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter with synchronous clear, enable and saturation at all-ones.
//   clk     - clock, posedge
//   reset   - synchronous active-high reset (count_o -> 0)
//   clr_i   - synchronous clear, wins over en_i
//   en_i    - count up by one when not saturated
//   count_o - current count
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_o <= '0;
        end else if (en_i && (count_o != '1)) begin
            count_o <= count_o + W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for one or more cpu cores. Sequences a core reset pulse,
// counts run cycles and detects completion (all cores halted, or watchdog timeout).
// Optional tohost exit-code capture is enabled by defining CPU_RUN_TOHOST_EN.
//   clk          - clock, posedge
//   reset        - synchronous active-high reset
//   start        - 1-cycle pulse, begins a run from IDLE/DONE/TIMEOUT
//   abort        - returns to IDLE from any state
//   halt_i       - per-core halt indication (level or pulse)
//   mem_we/mem_addr/mem_wdata - core store port snoop (CPU_RUN_TOHOST_EN only)
//   core_reset_o - active-high reset to the cores, low only while running
//   running/done/timed_out    - state flags
//   halted_mask  - sticky record of halts seen during the run
//   cycle_count  - run cycles elapsed, saturating
//   exit_code/pass            - tohost result (CPU_RUN_TOHOST_EN only)
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned N_CORES        = 1,
    parameter int unsigned RST_CYCLES     = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned TIMEOUT_CYCLES = 25
`ifdef CPU_RUN_TOHOST_EN
    ,
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [N_CORES-1:0] halt_i,
`ifdef CPU_RUN_TOHOST_EN
    input  logic               mem_we,
    input  logic [31:0]        mem_addr,
    input  logic [31:0]        mem_wdata,
    output logic [31:0]        exit_code,
    output logic               pass,
`endif
    output logic               core_reset_o,
    output logic               running,
    output logic               done,
    output logic               timed_out,
    output logic [N_CORES-1:0] halted_mask,
    output logic [CNT_W-1:0]   cycle_count
);

    localparam int unsigned    RST_W        = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q;
    logic [RST_W-1:0] rst_count;
    logic             launch;
    logic             rst_done;
    logic             all_halted;
    logic             timeout_hit;
    logic             to_done;
    logic             to_timeout;

    // A new run may only be launched from a resting state; abort beats start.
    assign launch = !abort && start &&
                    ((state_q == S_IDLE) || (state_q == S_DONE) || (state_q == S_TIMEOUT));

    // Reset pulse lasts RST_CYCLES+1 edges after the start edge.
    assign rst_done    = (rst_count == RST_W'(RST_CYCLES));
    // Include this cycle's halts so completion is seen without an extra cycle.
    assign all_halted  = &(halted_mask | halt_i);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cycle_count == TIMEOUT_LAST);

    always_comb begin
        to_done = all_halted;
`ifdef CPU_RUN_TOHOST_EN
        to_done = all_halted || (mem_we && (mem_addr == TOHOST_ADDR));
`endif
        to_timeout = !to_done && timeout_hit;
    end

    sat_counter #(
        .W (RST_W)
    ) u_rst_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (launch),
        .en_i    ((state_q == S_RST) && !abort),
        .count_o (rst_count)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_cycle_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (launch),
        .en_i    ((state_q == S_RUN) && !abort),
        .count_o (cycle_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            core_reset_o <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            timed_out    <= 1'b0;
            halted_mask  <= '0;
`ifdef CPU_RUN_TOHOST_EN
            exit_code    <= '0;
            pass         <= 1'b0;
`endif
        end else if (abort) begin
            // Counters and mask deliberately hold for post-mortem inspection.
            state_q      <= S_IDLE;
            core_reset_o <= 1'b1;
            running      <= 1'b0;
            done         <= 1'b0;
            timed_out    <= 1'b0;
`ifdef CPU_RUN_TOHOST_EN
            pass         <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE, S_TIMEOUT: begin
                    if (start) begin
                        state_q     <= S_RST;
                        done        <= 1'b0;
                        timed_out   <= 1'b0;
                        halted_mask <= '0;
`ifdef CPU_RUN_TOHOST_EN
                        pass        <= 1'b0;
`endif
                    end
                end
                S_RST: begin
                    if (rst_done) begin
                        state_q      <= S_RUN;
                        core_reset_o <= 1'b0;
                        running      <= 1'b1;
                    end
                end
                S_RUN: begin
                    halted_mask <= halted_mask | halt_i;
                    if (to_done) begin
                        state_q      <= S_DONE;
                        core_reset_o <= 1'b1;
                        running      <= 1'b0;
                        done         <= 1'b1;
`ifdef CPU_RUN_TOHOST_EN
                        // The tohost write outranks a simultaneous halt.
                        if (mem_we && (mem_addr == TOHOST_ADDR)) begin
                            exit_code <= mem_wdata;
                            pass      <= (mem_wdata == TOHOST_PASS);
                        end else begin
                            pass      <= (exit_code == TOHOST_PASS);
                        end
`endif
                    end else if (to_timeout) begin
                        state_q      <= S_TIMEOUT;
                        core_reset_o <= 1'b1;
                        running      <= 1'b0;
                        timed_out    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= S_IDLE;
                    core_reset_o <= 1'b1;
                    running      <= 1'b0;
                    done         <= 1'b0;
                    timed_out    <= 1'b0;
                end
            endcase
        end
    end

endmodule
